// File: rtl/suprloco_upload_ctrl.sv
// suprloco_upload_ctrl: serves HPS upload reads of the save RAM and
// raises upload requests, either manually or after a quiet period.
// Optional feature macro: SUPRLOCO_AUTOSAVE_EN. When it is defined, the
// block counts frames with no game writes and requests a save once the
// count reaches QUIET_FRAMES.
module suprloco_upload_ctrl #(
  parameter logic [15:0] UPLOAD_INDEX = 16'd4,
  parameter int          ADDR_WIDTH   = 11,
  parameter int          RD_LATENCY   = 2,
  parameter int          QUIET_FRAMES = 120
) (
  input  logic                  i_EMU_MCLK,
  input  logic                  i_EMU_INITRST,
  input  logic                  ioctl_upload,
  input  logic [15:0]           ioctl_index,
  input  logic                  ioctl_rd,
  input  logic [26:0]           ioctl_addr,
  output logic [7:0]            ioctl_din,
  output logic                  ioctl_wait,
  output logic                  ioctl_upload_req,
  output logic [ADDR_WIDTH-1:0] o_RAM_ADDR,
  output logic                  o_RAM_RD,
  input  logic [7:0]            i_RAM_DATA,
  input  logic                  i_RAM_WR,
  input  logic                  i_VBLANK_n,
  input  logic                  i_SAVE_REQ,
  output logic                  o_BUSY
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       session;
  logic       session_rise;
  logic       in_range;
  logic       dirty;
  logic       pending;
  logic       auto_hit;
  logic       save_trig;

  // o_BUSY holds last cycle's session state, so a low o_BUSY with an
  // active session marks the first cycle of that session.
  assign session      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign session_rise = session && !o_BUSY;
  assign in_range     = (ioctl_addr[26:ADDR_WIDTH] == '0);
  assign save_trig    = i_SAVE_REQ || auto_hit;

  // Read FSM: issue one RAM read, wait out its latency, return the byte.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state      <= IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      o_RAM_RD   <= 1'b0;
      o_RAM_ADDR <= '0;
      lat_cnt    <= 3'd0;
    end else begin
      o_RAM_RD <= 1'b0;
      case (state)
        IDLE: begin
          if (ioctl_rd && session) begin
            ioctl_wait <= 1'b1;
            if (in_range) begin
              o_RAM_ADDR <= ioctl_addr[ADDR_WIDTH-1:0];
              o_RAM_RD   <= 1'b1;
              lat_cnt    <= 3'd0;
              state      <= WAIT;
            end else begin
              state <= HOLD;
            end
          end
        end
        WAIT: begin
          // lat_cnt is 0 in the cycle o_RAM_RD is high; data is valid
          // when it reaches RD_LATENCY.
          if (lat_cnt == 3'(RD_LATENCY)) begin
            ioctl_din  <= i_RAM_DATA;
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        HOLD: begin
          ioctl_din  <= 8'hFF;
          ioctl_wait <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Session tracking, dirty flag and the upload request level.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      o_BUSY           <= 1'b0;
      dirty            <= 1'b0;
      pending          <= 1'b0;
      ioctl_upload_req <= 1'b0;
    end else begin
      o_BUSY <= session;
      if (i_RAM_WR)          dirty <= 1'b1;
      else if (session_rise) dirty <= 1'b0;
      if (session_rise) begin
        ioctl_upload_req <= 1'b0;
        if (save_trig) pending <= 1'b1;
      end else if (session) begin
        if (save_trig) pending <= 1'b1;
      end else begin
        if (save_trig || pending) ioctl_upload_req <= 1'b1;
        pending <= 1'b0;
      end
    end
  end

`ifdef SUPRLOCO_AUTOSAVE_EN
  localparam int CNT_W = $clog2(QUIET_FRAMES + 1);

  logic             vblank_d;
  logic             vb_fall;
  logic [CNT_W-1:0] frame_cnt;

  assign vb_fall  = vblank_d && !i_VBLANK_n;
  // Fires once, on the frame that brings the counter up to QUIET_FRAMES.
  assign auto_hit = vb_fall && dirty && !i_RAM_WR &&
                    (frame_cnt == CNT_W'(QUIET_FRAMES - 1));

  // Quiet-frame counter: restarts on every game write, saturates at target.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      vblank_d  <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vblank_d <= i_VBLANK_n;
      if (i_RAM_WR)
        frame_cnt <= '0;
      else if (vb_fall && dirty && (frame_cnt != CNT_W'(QUIET_FRAMES)))
        frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  logic unused_autosave;

  assign auto_hit        = 1'b0;
  assign unused_autosave = ^{i_VBLANK_n, dirty};
`endif

endmodule

// File: tb/tb_suprloco_upload_ctrl.sv
// Directed bench for suprloco_upload_ctrl (default parameters).
module tb_suprloco_upload_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ioctl_upload;
  logic [15:0] ioctl_index;
  logic        ioctl_rd;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic [10:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data;
  logic        ram_wr;
  logic        vblank_n;
  logic        save_req;
  logic        busy;

  logic [7:0]  mem [0:2047];
  logic [7:0]  r1, r2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Two-cycle read latency save RAM.
  always @(posedge clk) begin
    r1 <= mem[ram_addr];
    r2 <= r1;
  end
  assign ram_data = r2;

  suprloco_upload_ctrl dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_INITRST    (rst),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .ioctl_upload_req (ioctl_upload_req),
    .o_RAM_ADDR       (ram_addr),
    .o_RAM_RD         (ram_rd),
    .i_RAM_DATA       (ram_data),
    .i_RAM_WR         (ram_wr),
    .i_VBLANK_n       (vblank_n),
    .i_SAVE_REQ       (save_req),
    .o_BUSY           (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_fall();
    vblank_n = 1'b0;
    tick();
    vblank_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    mem[5]     = 8'hA7;
    mem[11'h7FF] = 8'h3C;
    rst = 1'b1; ioctl_upload = 1'b0; ioctl_index = 16'd0; ioctl_rd = 1'b0;
    ioctl_addr = 27'd0; ram_wr = 1'b0; vblank_n = 1'b1; save_req = 1'b0;
    tick(); tick();
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_req", ioctl_upload_req, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Start a matching session.
    ioctl_upload = 1'b1; ioctl_index = 16'd4;
    tick();
    chk("busy_on", busy, 1);

    // In-range read of address 5.
    ioctl_rd = 1'b1; ioctl_addr = 27'h005;
    tick();
    ioctl_rd = 1'b0;
    chk("rd5_strobe", ram_rd, 1);
    chk("rd5_addr", ram_addr, 11'h005);
    chk("rd5_wait0", ioctl_wait, 1);
    tick();
    chk("rd5_strobe_off", ram_rd, 0);
    chk("rd5_wait1", ioctl_wait, 1);
    tick();
    chk("rd5_wait2", ioctl_wait, 1);
    tick();
    chk("rd5_wait3", ioctl_wait, 0);
    chk("rd5_din", ioctl_din, 8'hA7);

    // Top in-range address.
    ioctl_rd = 1'b1; ioctl_addr = 27'h7FF;
    tick();
    ioctl_rd = 1'b0;
    chk("rd7ff_addr", ram_addr, 11'h7FF);
    tick(); tick(); tick();
    chk("rd7ff_wait", ioctl_wait, 0);
    chk("rd7ff_din", ioctl_din, 8'h3C);

    // First out-of-range address.
    ioctl_rd = 1'b1; ioctl_addr = 27'h800;
    tick();
    ioctl_rd = 1'b0;
    chk("oor_strobe", ram_rd, 0);
    chk("oor_wait0", ioctl_wait, 1);
    tick();
    chk("oor_wait1", ioctl_wait, 0);
    chk("oor_din", ioctl_din, 8'hFF);

    // Read with a non-matching index is ignored.
    ioctl_index = 16'd0; ioctl_rd = 1'b1; ioctl_addr = 27'h005;
    tick();
    ioctl_rd = 1'b0;
    chk("ns_wait", ioctl_wait, 0);
    chk("ns_strobe", ram_rd, 0);
    chk("ns_busy", busy, 0);
    tick(); tick(); tick();
    chk("ns_din", ioctl_din, 8'hFF);

    // Manual save during a session: deferred until the session ends.
    ioctl_index = 16'd4;
    tick();
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    chk("pend_req_in_sess", ioctl_upload_req, 0);
    tick();
    ioctl_upload = 1'b0;
    chk("pend_req_at_fall", ioctl_upload_req, 0);
    tick();
    chk("pend_req_after", ioctl_upload_req, 1);
    tick(); tick();
    chk("req_level_hold", ioctl_upload_req, 1);
    ioctl_upload = 1'b1;
    tick();
    chk("req_clr_on_start", ioctl_upload_req, 0);

    // Session start and save request together: start wins.
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1; save_req = 1'b1;
    tick();
    save_req = 1'b0;
    chk("coinc_req", ioctl_upload_req, 0);
    ioctl_upload = 1'b0;
    tick();
    chk("coinc_pend_req", ioctl_upload_req, 1);

    // Clear the request, then a manual save outside any session.
    ioctl_upload = 1'b1;
    tick();
    ioctl_upload = 1'b0;
    tick();
    chk("idle_req_clear", ioctl_upload_req, 0);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    chk("idle_save_req", ioctl_upload_req, 1);

    // Session ends while a read is waiting on the RAM.
    ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 27'h005;
    tick();
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    chk("midend_wait0", ioctl_wait, 1);
    tick();
    chk("midend_wait1", ioctl_wait, 1);
    tick();
    chk("midend_wait2", ioctl_wait, 1);
    tick();
    chk("midend_wait3", ioctl_wait, 0);
    chk("midend_din", ioctl_din, 8'hA7);

    // Reset while waiting aborts the read.
    ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 27'h7FF;
    tick();
    ioctl_rd = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_wait", ioctl_wait, 0);
    chk("rstw_din", ioctl_din, 8'h00);
    chk("rstw_req", ioctl_upload_req, 0);
    tick(); tick(); tick();
    chk("rstw_no_late", ioctl_din, 8'h00);
    ioctl_rd = 1'b1; ioctl_addr = 27'h005;
    tick();
    ioctl_rd = 1'b0;
    chk("rstw_idle_rd", ram_rd, 1);
    tick(); tick(); tick();
    chk("rstw_idle_din", ioctl_din, 8'hA7);
    ioctl_upload = 1'b0;
    tick();

`ifdef SUPRLOCO_AUTOSAVE_EN
    // One write, then 120 quiet frames.
    ram_wr = 1'b1;
    tick();
    ram_wr = 1'b0;
    for (int f = 0; f < 119; f++) frame_fall();
    chk("auto_119", ioctl_upload_req, 0);
    vblank_n = 1'b0;
    tick();
    vblank_n = 1'b1;
    chk("auto_120", ioctl_upload_req, 1);
    tick();

    // Clear request and dirty via a session, then restart with a write at frame 60.
    ioctl_upload = 1'b1;
    tick();
    ioctl_upload = 1'b0;
    tick();
    chk("auto_clr", ioctl_upload_req, 0);
    ram_wr = 1'b1;
    tick();
    ram_wr = 1'b0;
    for (int f = 0; f < 60; f++) frame_fall();
    ram_wr = 1'b1;
    tick();
    ram_wr = 1'b0;
    for (int f = 0; f < 60; f++) frame_fall();
    chk("auto_delay_120", ioctl_upload_req, 0);
    for (int f = 0; f < 59; f++) frame_fall();
    chk("auto_delay_179", ioctl_upload_req, 0);
    vblank_n = 1'b0;
    tick();
    vblank_n = 1'b1;
    chk("auto_delay_180", ioctl_upload_req, 1);
`else
    // Without autosave, writes and quiet frames never request a save.
    ram_wr = 1'b1;
    tick();
    ram_wr = 1'b0;
    for (int f = 0; f < 130; f++) frame_fall();
    chk("noauto_req", ioctl_upload_req, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
